// File: rtl/demux_route_ctrl.sv
// demux_route_ctrl: takes a word and a destination lane over valid/ready and
// shifts the word MSB-first onto the demux data input. selection_line stays on
// the destination for the whole frame. An even-parity bit and idle gap cycles
// can follow the data bits.
//
// state  | meaning
// IDLE   | waiting for in_valid; i=0, selection_line keeps its last value
// SHIFT  | data bits on i, bit index counts WIDTH-1 down to 0
// PARITY | XOR of the latched word on i
// GAP_S  | GAP idle cycles before the next word is accepted
module demux_route_ctrl #(
  parameter int WIDTH     = 8,
  parameter int GAP       = 1,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       dest,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             i,
  output logic [1:0]       selection_line,
  output logic             active,
  output logic             frame_done
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_TOP  = IW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, GAP_S} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [3:0]       gap_q, gap_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [1:0]       sel_d;
  logic             i_d, active_d, fd_d;

  assign in_ready = (state_q == IDLE) && !rst;

  // State, counters, latched word and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      gap_q          <= '0;
      word_q         <= '0;
      selection_line <= 2'b00;
      i              <= 1'b0;
      active         <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      gap_q          <= gap_d;
      word_q         <= word_d;
      selection_line <= sel_d;
      i              <= i_d;
      active         <= active_d;
      frame_done     <= fd_d;
    end
  end

  // Next state and counter/latch updates; the bit counter stops at 0 and
  // leaves SHIFT instead of wrapping.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    word_d  = word_q;
    sel_d   = selection_line;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          word_d  = data_in;
          sel_d   = dest;
          idx_d   = IDX_TOP;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (idx_q == '0) begin
          gap_d = GAP_LAST;
          if (PARITY_EN)    state_d = PARITY;
          else if (GAP > 0) state_d = GAP_S;
          else              state_d = IDLE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      PARITY: begin
        gap_d   = GAP_LAST;
        state_d = (GAP > 0) ? GAP_S : IDLE;
      end
      GAP_S: begin
        if (gap_q == 4'd0) state_d = IDLE;
        else               gap_d   = gap_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values decoded from the upcoming state so they appear with it.
  always_comb begin
    i_d      = 1'b0;
    active_d = 1'b0;
    fd_d     = 1'b0;
    unique case (state_d)
      SHIFT: begin
        i_d      = word_d[idx_d];
        active_d = 1'b1;
        fd_d     = !PARITY_EN && (idx_d == '0);
      end
      PARITY: begin
        i_d      = ^word_d;
        active_d = 1'b1;
        fd_d     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_demux_route_ctrl.sv
// Directed bench for demux_route_ctrl: one instance with parity and a one-cycle
// gap, one instance with neither.
module tb_demux_route_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a_data, b_data;
  logic [1:0] a_dest, b_dest;
  logic       a_valid, b_valid;
  logic       a_ready, b_ready;
  logic       a_i, b_i;
  logic [1:0] a_sel, b_sel;
  logic       a_active, b_active;
  logic       a_fd, b_fd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_route_ctrl #(.WIDTH(8), .GAP(1), .PARITY_EN(1'b1)) u_a (
    .clk(clk), .rst(rst), .data_in(a_data), .dest(a_dest), .in_valid(a_valid),
    .in_ready(a_ready), .i(a_i), .selection_line(a_sel), .active(a_active),
    .frame_done(a_fd)
  );

  demux_route_ctrl #(.WIDTH(8), .GAP(0), .PARITY_EN(1'b0)) u_b (
    .clk(clk), .rst(rst), .data_in(b_data), .dest(b_dest), .in_valid(b_valid),
    .in_ready(b_ready), .i(b_i), .selection_line(b_sel), .active(b_active),
    .frame_done(b_fd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks one full data frame on instance A, starting in the first bit cycle.
  task automatic frame_a(input logic [7:0] w, input logic [1:0] d, input logic par);
    for (int k = 0; k < 8; k++) begin
      chk("a_bit", a_i, w[7-k]);
      chk("a_sel", a_sel, d);
      chk("a_active", a_active, 1'b1);
      chk("a_fd_low", a_fd, 1'b0);
      chk("a_ready_busy", a_ready, 1'b0);
      a_valid = k[0];
      a_data  = ~w ^ 8'(k);
      a_dest  = ~d;
      tick();
    end
    a_valid = 1'b0;
    chk("a_parity", a_i, par);
    chk("a_par_active", a_active, 1'b1);
    chk("a_par_fd", a_fd, 1'b1);
    chk("a_par_sel", a_sel, d);
    tick();
    chk("a_gap_i", a_i, 1'b0);
    chk("a_gap_active", a_active, 1'b0);
    chk("a_gap_fd", a_fd, 1'b0);
    chk("a_gap_sel", a_sel, d);
    chk("a_gap_ready", a_ready, 1'b0);
    tick();
    chk("a_idle_ready", a_ready, 1'b1);
    chk("a_idle_sel_hold", a_sel, d);
    chk("a_idle_active", a_active, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    a_data = 8'h00; a_dest = 2'd0; a_valid = 1'b0;
    b_data = 8'h00; b_dest = 2'd0; b_valid = 1'b0;
    tick();
    tick();
    chk("rst_ready", a_ready, 1'b0);
    chk("rst_i", a_i, 1'b0);
    chk("rst_sel", a_sel, 2'b00);
    chk("rst_active", a_active, 1'b0);
    chk("rst_fd", a_fd, 1'b0);

    // in_valid held through reset: no accept until rst is low
    a_valid = 1'b1; a_data = 8'hA5; a_dest = 2'd2;
    tick();
    chk("rst_no_accept", a_active, 1'b0);
    chk("rst_ready_hold", a_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("release_ready", a_ready, 1'b1);
    chk("release_idle_i", a_i, 1'b0);
    tick();
    frame_a(8'hA5, 2'd2, 1'b0);

    a_valid = 1'b1; a_data = 8'h07; a_dest = 2'd3;
    tick();
    frame_a(8'h07, 2'd3, 1'b1);

    // back-to-back frames on B with in_valid held high
    b_valid = 1'b1; b_data = 8'hFF; b_dest = 2'd0;
    tick();
    b_data = 8'h00; b_dest = 2'd1;
    for (int k = 0; k < 8; k++) begin
      chk("b_bit_ff", b_i, 1'b1);
      chk("b_sel0", b_sel, 2'd0);
      chk("b_active", b_active, 1'b1);
      chk("b_fd", b_fd, (k == 7) ? 1'b1 : 1'b0);
      tick();
    end
    chk("b_idle_ready", b_ready, 1'b1);
    chk("b_idle_active", b_active, 1'b0);
    tick();
    chk("b_second_accept", b_active, 1'b1);
    chk("b_sel1", b_sel, 2'd1);
    b_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("b_bit_00", b_i, 1'b0);
      chk("b_sel1_hold", b_sel, 2'd1);
      chk("b_fd2", b_fd, (k == 7) ? 1'b1 : 1'b0);
      tick();
    end
    chk("b_end_active", b_active, 1'b0);

    // reset in the 4th bit of a frame
    a_valid = 1'b1; a_data = 8'h3C; a_dest = 2'd1;
    tick();
    a_valid = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_bit3", a_i, 1'b1);
    chk("pre_rst_sel", a_sel, 2'd1);
    rst = 1'b1;
    #1;
    chk("async_i", a_i, 1'b0);
    chk("async_active", a_active, 1'b0);
    chk("async_fd", a_fd, 1'b0);
    chk("async_sel", a_sel, 2'b00);
    chk("async_ready", a_ready, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk("rerelease_ready", a_ready, 1'b1);
    chk("rerelease_active", a_active, 1'b0);
    a_valid = 1'b1; a_data = 8'h81; a_dest = 2'd2;
    tick();
    frame_a(8'h81, 2'd2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
